// File: rtl/polyvec_ram_ctrl.sv
// polyvec_ram_ctrl: access controller for the 4-lane polynomial-vector RAM.
// A load/unload engine moves one polynomial between a serial coefficient
// stream and one lane. The arithmetic core can take the whole RAM whenever
// the controller is idle. Loads use a single-cycle read-modify-write so the
// other three lanes of each word are written back unchanged.
//
// Handshakes: every stream transfers a word on a rising edge where valid and
// ready are both high. A source holds valid and data stable until that edge.
// A sink may raise or drop ready at any time. The same rule applies to
// cmd_valid/cmd_ready, s_valid/s_ready and m_valid/m_ready.
module polyvec_ram_ctrl #(
    parameter int addr_width = 8,
    parameter int depth      = 256,
    parameter int data_width = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [1:0]            cmd_lane,
    output logic                  done,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [data_width-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [data_width-1:0] m_data,
    input  logic                  core_req,
    output logic                  core_gnt,
    input  logic                  core_wen,
    input  logic [addr_width-1:0] core_raddr,
    input  logic [addr_width-1:0] core_waddr,
    input  logic [data_width-1:0] core_din0,
    input  logic [data_width-1:0] core_din1,
    input  logic [data_width-1:0] core_din2,
    input  logic [data_width-1:0] core_din3,
    output logic                  ram_wen,
    output logic [addr_width-1:0] ram_raddr,
    output logic [addr_width-1:0] ram_waddr,
    output logic [data_width-1:0] ram_din0,
    output logic [data_width-1:0] ram_din1,
    output logic [data_width-1:0] ram_din2,
    output logic [data_width-1:0] ram_din3,
    input  logic [data_width-1:0] ram_dout0,
    input  logic [data_width-1:0] ram_dout1,
    input  logic [data_width-1:0] ram_dout2,
    input  logic [data_width-1:0] ram_dout3,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        UNLOAD = 2'd2,
        CORE   = 2'd3
    } state_t;

    // cnt has one extra bit so UNLOAD can tell "all depth words fetched" apart from word 0
    localparam logic [addr_width:0] cnt_last = (addr_width + 1)'(depth - 1);
    localparam logic [addr_width:0] cnt_full = (addr_width + 1)'(depth);

    state_t                  state;
    logic [1:0]              lane_q;
    logic [addr_width:0]     cnt;
    logic [data_width-1:0]   dout [4];
    logic [data_width-1:0]   din  [4];
    logic                    fetch;

    assign dout[0] = ram_dout0;
    assign dout[1] = ram_dout1;
    assign dout[2] = ram_dout2;
    assign dout[3] = ram_dout3;

    assign ram_din0  = din[0];
    assign ram_din1  = din[1];
    assign ram_din2  = din[2];
    assign ram_din3  = din[3];
    assign dbg_state = state;

    // Commands are only taken in IDLE when the core is not asking; held low in reset
    assign cmd_ready = rst_n & (state == IDLE) & ~core_req;

    // The output register can take a new word when empty or being drained this cycle
    assign fetch = (state == UNLOAD) && (!m_valid || m_ready) && (cnt != cnt_full);

    // RAM port mux: core passthrough when granted, otherwise the engine's RMW path
    always_comb begin
        ram_wen   = 1'b0;
        ram_raddr = cnt[addr_width-1:0];
        ram_waddr = cnt[addr_width-1:0];
        for (int i = 0; i < 4; i++) din[i] = dout[i];
        if (state == CORE) begin
            ram_wen   = core_wen;
            ram_raddr = core_raddr;
            ram_waddr = core_waddr;
            din[0]    = core_din0;
            din[1]    = core_din1;
            din[2]    = core_din2;
            din[3]    = core_din3;
        end else if (state == LOAD) begin
            ram_wen      = s_valid & s_ready;
            din[lane_q]  = s_data;
        end
    end

    // Controller FSM with registered status and stream outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lane_q   <= 2'd0;
            cnt      <= '0;
            done     <= 1'b0;
            s_ready  <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            core_gnt <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (core_req) begin
                        state    <= CORE;
                        core_gnt <= 1'b1;
                    end else if (cmd_valid) begin
                        lane_q <= cmd_lane;
                        cnt    <= '0;
                        if (cmd_op) begin
                            state <= UNLOAD;
                        end else begin
                            state   <= LOAD;
                            s_ready <= 1'b1;
                        end
                    end
                end
                CORE: begin
                    if (!core_req) begin
                        state    <= IDLE;
                        core_gnt <= 1'b0;
                    end
                end
                LOAD: begin
                    if (s_valid && s_ready) begin
                        if (cnt == cnt_last) begin
                            cnt     <= '0;
                            s_ready <= 1'b0;
                            done    <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                UNLOAD: begin
                    if (fetch) begin
                        m_data  <= dout[lane_q];
                        m_valid <= 1'b1;
                        cnt     <= cnt + 1'b1;
                    end else if (m_valid && m_ready) begin
                        m_valid <= 1'b0;
                        cnt     <= '0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_polyvec_ram_ctrl.sv
// Directed bench for polyvec_ram_ctrl with a behavioural 4-lane RAM attached.
module tb_polyvec_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_op = 1'b0;
    logic [1:0]  cmd_lane = 2'd0;
    logic        done;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [11:0] s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [11:0] m_data;
    logic        core_req = 1'b0;
    logic        core_gnt;
    logic        core_wen = 1'b0;
    logic [7:0]  core_raddr = '0;
    logic [7:0]  core_waddr = '0;
    logic [11:0] core_din0 = '0, core_din1 = '0, core_din2 = '0, core_din3 = '0;
    logic        ram_wen;
    logic [7:0]  ram_raddr, ram_waddr;
    logic [11:0] ram_din0, ram_din1, ram_din2, ram_din3;
    logic [11:0] ram_dout0, ram_dout1, ram_dout2, ram_dout3;
    logic [1:0]  dbg_state;

    logic [11:0] mem [4][256];
    logic        preload = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    polyvec_ram_ctrl #(.addr_width(8), .depth(256), .data_width(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_lane(cmd_lane),
        .done(done),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .core_req(core_req), .core_gnt(core_gnt), .core_wen(core_wen),
        .core_raddr(core_raddr), .core_waddr(core_waddr),
        .core_din0(core_din0), .core_din1(core_din1), .core_din2(core_din2), .core_din3(core_din3),
        .ram_wen(ram_wen), .ram_raddr(ram_raddr), .ram_waddr(ram_waddr),
        .ram_din0(ram_din0), .ram_din1(ram_din1), .ram_din2(ram_din2), .ram_din3(ram_din3),
        .ram_dout0(ram_dout0), .ram_dout1(ram_dout1), .ram_dout2(ram_dout2), .ram_dout3(ram_dout3),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // 4-lane RAM: combinational read, synchronous write, bulk fill to 7
    always @(posedge clk) begin
        if (preload) begin
            for (int l = 0; l < 4; l++)
                for (int a = 0; a < 256; a++) mem[l][a] <= 12'd7;
        end else if (ram_wen) begin
            mem[0][ram_waddr] <= ram_din0;
            mem[1][ram_waddr] <= ram_din1;
            mem[2][ram_waddr] <= ram_din2;
            mem[3][ram_waddr] <= ram_din3;
        end
    end
    assign ram_dout0 = mem[0][ram_raddr];
    assign ram_dout1 = mem[1][ram_raddr];
    assign ram_dout2 = mem[2][ram_raddr];
    assign ram_dout3 = mem[3][ram_raddr];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic op, input logic [1:0] lane);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_lane  = lane;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        preload = 1'b1;
        tick();
        tick();
        preload = 1'b0;
        n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_cmd_ready: got %0b want 0", cmd_ready); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %0b want 0", done); end
        n_vec++; if (core_gnt !== 1'b0) begin n_err++; $display("FAIL rst_core_gnt: got %0b want 0", core_gnt); end
        n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL rst_s_ready: got %0b want 0", s_ready); end
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_m_valid: got %0b want 0", m_valid); end
        n_vec++; if (m_data !== 12'd0) begin n_err++; $display("FAIL rst_m_data: got %0d want 0", m_data); end
        n_vec++; if (ram_wen !== 1'b0) begin n_err++; $display("FAIL rst_ram_wen: got %0b want 0", ram_wen); end
        n_vec++; if (ram_raddr !== 8'd0 || ram_waddr !== 8'd0) begin n_err++; $display("FAIL rst_ram_addr: got %0d/%0d want 0/0", ram_raddr, ram_waddr); end
        n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL idle_cmd_ready: got %0b want 1", cmd_ready); end
    endtask

    task automatic test_load_full();
        int cycles;
        logic [47:0] exp_w, got_w;
        set_cmd(1'b0, 2'd2);
        #1;
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL load_accept: got %0b want 1", cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        cycles = 1;
        n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL load_s_ready: got %0b want 1", s_ready); end
        for (int i = 0; i < 256; i++) begin
            s_valid = 1'b1;
            s_data  = 12'(100 + i);
            #1;
            n_vec++; if (ram_wen !== 1'b1 || ram_waddr !== 8'(i)) begin n_err++; $display("FAIL load_write: wen=%0b addr=%0d want 1/%0d", ram_wen, ram_waddr, i); end
            n_vec++; if (ram_din2 !== 12'(100 + i) || ram_din0 !== 12'd7 || ram_din1 !== 12'd7 || ram_din3 !== 12'd7) begin
                n_err++; $display("FAIL load_rmw_din: got %0d %0d %0d %0d want 7 7 %0d 7", ram_din0, ram_din1, ram_din2, ram_din3, 100 + i);
            end
            n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL load_done_early: got %0b want 0 at beat %0d", done, i); end
            tick();
            cycles++;
        end
        s_valid = 1'b0;
        n_vec++; if (done !== 1'b1 || cycles != 257) begin n_err++; $display("FAIL load_done: done=%0b after %0d cycles want 1 after 257", done, cycles); end
        n_vec++; if (s_ready !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL load_end_ready: s_ready=%0b cmd_ready=%0b want 0/1", s_ready, cmd_ready); end
        tick();
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL load_done_pulse: got %0b want 0", done); end
        for (int i = 0; i < 256; i++) begin
            exp_w = {12'd7, 12'(100 + i), 12'd7, 12'd7};
            got_w = {mem[3][i], mem[2][i], mem[1][i], mem[0][i]};
            n_vec++; if (got_w !== exp_w) begin n_err++; $display("FAIL load_mem[%0d]: got %h want %h", i, got_w, exp_w); end
        end
    endtask

    task automatic test_unload_stall();
        int k;
        logic ph, stalled;
        logic [11:0] held;
        k = 0; ph = 1'b1; stalled = 1'b0; held = '0;
        set_cmd(1'b1, 2'd2);
        #1;
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL unload_accept: got %0b want 1", cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL unload_first_cycle: m_valid=%0b want 0", m_valid); end
        for (int cyc = 0; cyc < 1000 && k < 256; cyc++) begin
            if (stalled) begin
                n_vec++; if (m_valid !== 1'b1 || m_data !== held) begin n_err++; $display("FAIL unload_hold: got v=%0b d=%0d want 1/%0d", m_valid, m_data, held); end
            end
            n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL unload_done_early: got %0b want 0 at word %0d", done, k); end
            m_ready = ph;
            ph = ~ph;
            if (m_valid && m_ready) begin
                n_vec++; if (m_data !== 12'(100 + k)) begin n_err++; $display("FAIL unload_data[%0d]: got %0d want %0d", k, m_data, 100 + k); end
                k++;
                stalled = 1'b0;
            end else begin
                stalled = m_valid;
                held = m_data;
            end
            tick();
        end
        m_ready = 1'b0;
        n_vec++; if (k != 256) begin n_err++; $display("FAIL unload_count: got %0d words want 256", k); end
        n_vec++; if (done !== 1'b1 || m_valid !== 1'b0) begin n_err++; $display("FAIL unload_done: done=%0b m_valid=%0b want 1/0", done, m_valid); end
        tick();
        n_vec++; if (done !== 1'b0 || dbg_state !== 2'd0) begin n_err++; $display("FAIL unload_after: done=%0b state=%0d want 0/0", done, dbg_state); end
    endtask

    task automatic test_core_priority();
        core_req = 1'b1;
        set_cmd(1'b0, 2'd0);
        #1;
        n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL prio_cmd_ready: got %0b want 0", cmd_ready); end
        n_vec++; if (core_gnt !== 1'b0) begin n_err++; $display("FAIL prio_gnt_early: got %0b want 0", core_gnt); end
        tick();
        n_vec++; if (core_gnt !== 1'b1 || cmd_ready !== 1'b0) begin n_err++; $display("FAIL prio_grant: gnt=%0b cmd_ready=%0b want 1/0", core_gnt, cmd_ready); end
        core_wen = 1'b1; core_waddr = 8'd5; core_raddr = 8'd9;
        core_din0 = 12'hA01; core_din1 = 12'hA02; core_din2 = 12'hA03; core_din3 = 12'hA04;
        #1;
        n_vec++; if (ram_wen !== 1'b1 || ram_waddr !== 8'd5 || ram_raddr !== 8'd9) begin n_err++; $display("FAIL core_fwd_ctl: wen=%0b wa=%0d ra=%0d want 1/5/9", ram_wen, ram_waddr, ram_raddr); end
        n_vec++; if ({ram_din3, ram_din2, ram_din1, ram_din0} !== 48'hA04A03A02A01) begin n_err++; $display("FAIL core_fwd_din: got %h want a04a03a02a01", {ram_din3, ram_din2, ram_din1, ram_din0}); end
        tick();
        core_wen = 1'b0;
        core_req = 1'b0;
        #1;
        n_vec++; if (ram_wen !== 1'b0 || core_gnt !== 1'b1) begin n_err++; $display("FAIL core_release_cycle: wen=%0b gnt=%0b want 0/1", ram_wen, core_gnt); end
        tick();
        n_vec++; if (core_gnt !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL core_released: gnt=%0b cmd_ready=%0b want 0/1", core_gnt, cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        n_vec++; if (dbg_state !== 2'd1 || s_ready !== 1'b1) begin n_err++; $display("FAIL prio_cmd_taken: state=%0d s_ready=%0b want 1/1", dbg_state, s_ready); end
    endtask

    task automatic test_core_during_load();
        logic [47:0] exp_w, got_w;
        for (int i = 0; i < 256; i++) begin
            s_valid = 1'b1;
            s_data  = 12'(500 + i);
            if (i == 50) core_req = 1'b1;
            #1;
            n_vec++; if (core_gnt !== 1'b0) begin n_err++; $display("FAIL mid_load_gnt: got %0b want 0 at beat %0d", core_gnt, i); end
            tick();
        end
        s_valid = 1'b0;
        n_vec++; if (done !== 1'b1 || core_gnt !== 1'b0 || dbg_state !== 2'd0) begin
            n_err++; $display("FAIL mid_load_done: done=%0b gnt=%0b state=%0d want 1/0/0", done, core_gnt, dbg_state);
        end
        tick();
        n_vec++; if (core_gnt !== 1'b1) begin n_err++; $display("FAIL mid_load_grant: got %0b want 1", core_gnt); end
        core_req = 1'b0;
        tick();
        n_vec++; if (core_gnt !== 1'b0) begin n_err++; $display("FAIL mid_load_release: got %0b want 0", core_gnt); end
        for (int i = 0; i < 256; i++) begin
            exp_w = (i == 5) ? {12'hA04, 12'hA03, 12'hA02, 12'(505)} : {12'd7, 12'(100 + i), 12'd7, 12'(500 + i)};
            got_w = {mem[3][i], mem[2][i], mem[1][i], mem[0][i]};
            n_vec++; if (got_w !== exp_w) begin n_err++; $display("FAIL lane0_mem[%0d]: got %h want %h", i, got_w, exp_w); end
        end
    endtask

    task automatic test_gap_load();
        int i;
        logic gap;
        logic [47:0] exp_w, got_w;
        i = 0;
        set_cmd(1'b0, 2'd1);
        #1;
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL gap_accept: got %0b want 1", cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        for (int cyc = 0; cyc < 1000 && i < 256; cyc++) begin
            gap = (cyc % 3 == 2);
            s_valid = ~gap;
            s_data  = 12'(100 + i);
            #1;
            n_vec++; if (ram_wen !== ~gap || ram_waddr !== 8'(i) || s_ready !== 1'b1) begin
                n_err++; $display("FAIL gap_write: wen=%0b addr=%0d s_ready=%0b want %0b/%0d/1", ram_wen, ram_waddr, s_ready, ~gap, i);
            end
            tick();
            if (!gap) i++;
        end
        s_valid = 1'b0;
        n_vec++; if (i != 256 || done !== 1'b1) begin n_err++; $display("FAIL gap_done: beats=%0d done=%0b want 256/1", i, done); end
        tick();
        for (int a = 0; a < 256; a++) begin
            exp_w = (a == 5) ? {12'hA04, 12'hA03, 12'(105), 12'(505)} : {12'd7, 12'(100 + a), 12'(100 + a), 12'(500 + a)};
            got_w = {mem[3][a], mem[2][a], mem[1][a], mem[0][a]};
            n_vec++; if (got_w !== exp_w) begin n_err++; $display("FAIL gap_mem[%0d]: got %h want %h", a, got_w, exp_w); end
        end
    endtask

    task automatic test_reset_mid_unload();
        int k;
        logic hit;
        k = 0; hit = 1'b0;
        m_ready = 1'b1;
        set_cmd(1'b1, 2'd1);
        tick();
        cmd_valid = 1'b0;
        for (int cyc = 0; cyc < 400 && !hit; cyc++) begin
            if (ram_raddr == 8'd128) begin
                hit = 1'b1;
            end else begin
                if (m_valid) begin
                    n_vec++; if (m_data !== 12'(100 + k)) begin n_err++; $display("FAIL pre_rst_data[%0d]: got %0d want %0d", k, m_data, 100 + k); end
                    k++;
                end
                tick();
            end
        end
        n_vec++; if (!hit || k != 127) begin n_err++; $display("FAIL pre_rst_reach: hit=%0b words=%0d want 1/127", hit, k); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (m_valid !== 1'b0 || m_data !== 12'd0 || done !== 1'b0) begin n_err++; $display("FAIL mid_rst_stream: v=%0b d=%0d done=%0b want 0/0/0", m_valid, m_data, done); end
        n_vec++; if (cmd_ready !== 1'b0 || dbg_state !== 2'd0 || ram_raddr !== 8'd0 || s_ready !== 1'b0 || core_gnt !== 1'b0) begin
            n_err++; $display("FAIL mid_rst_ctl: cmd_ready=%0b state=%0d raddr=%0d s_ready=%0b gnt=%0b want 0/0/0/0/0", cmd_ready, dbg_state, ram_raddr, s_ready, core_gnt);
        end
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        k = 0;
        set_cmd(1'b1, 2'd1);
        tick();
        cmd_valid = 1'b0;
        for (int cyc = 0; cyc < 600 && k < 256; cyc++) begin
            if (m_valid) begin
                n_vec++; if (m_data !== 12'(100 + k)) begin n_err++; $display("FAIL re_unload[%0d]: got %0d want %0d", k, m_data, 100 + k); end
                k++;
            end
            tick();
        end
        n_vec++; if (k != 256 || done !== 1'b1) begin n_err++; $display("FAIL re_unload_done: words=%0d done=%0b want 256/1", k, done); end
        m_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_load_full();
        test_unload_stall();
        test_core_priority();
        test_core_during_load();
        test_gap_load();
        test_reset_mid_unload();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
